// File: rtl/mood_pkg.sv
// Shared indices for the mood loop: emotion/stimulus/action bit positions,
// neurotransmitter channel numbering and packed-bus slot offsets.
package mood_pkg;

    localparam int unsigned EMO_HAPPY     = 0;
    localparam int unsigned EMO_EXCITED   = 1;
    localparam int unsigned EMO_STRESSED  = 2;
    localparam int unsigned EMO_NERVOUS   = 3;
    localparam int unsigned EMO_BORED     = 4;
    localparam int unsigned EMO_ANGRY     = 5;
    localparam int unsigned EMO_CALM      = 6;
    localparam int unsigned EMO_APATHETIC = 7;

    localparam int unsigned STIM_HUNGRY   = 11;
    localparam int unsigned STIM_STARVING = 12;
    localparam int unsigned STIM_TIRED    = 13;

    localparam int unsigned ACT_ASLEEP    = 0;

    localparam int unsigned NT_CORT = 0;
    localparam int unsigned NT_DOP  = 2;
    localparam int unsigned NT_GABA = 4;
    localparam int unsigned NT_NE   = 6;
    localparam int unsigned NT_SER  = 8;

    localparam int unsigned CH_CORT = 0;
    localparam int unsigned CH_DOP  = 1;
    localparam int unsigned CH_GABA = 2;
    localparam int unsigned CH_NE   = 3;
    localparam int unsigned CH_SER  = 4;

    localparam int unsigned NT_NUM    = 5;
    localparam int unsigned NT_SLOT_W = 2;
    localparam int unsigned NT_BUS_W  = NT_NUM * NT_SLOT_W;

    typedef struct packed {
        logic [NT_NUM-1:0] inc;
        logic [NT_NUM-1:0] dec;
    } nt_req_t;

endpackage

// File: rtl/nt_channel.sv
// One neurotransmitter level: saturating up/down integrator that drifts one
// step toward BASELINE on decay pulses when no request is pending.
module nt_channel #(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned BASELINE = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             inc,
    input  logic             dec,
    input  logic             decay,
    output logic [WIDTH-1:0] level
);

    localparam logic [WIDTH-1:0] L_BASE = WIDTH'(BASELINE);
    localparam logic [WIDTH-1:0] L_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] L_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_level;

    // Conflicting requests freeze the level, including suppressing decay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= L_BASE;
        end else if (tick) begin
            if (inc && !dec) begin
                if (r_level != L_MAX) r_level <= r_level + L_ONE;
            end else if (dec && !inc) begin
                if (r_level != '0) r_level <= r_level - L_ONE;
            end else if (!inc && !dec && decay) begin
                if (r_level > L_BASE)      r_level <= r_level - L_ONE;
                else if (r_level < L_BASE) r_level <= r_level + L_ONE;
            end
        end
    end

    assign level = r_level;

endmodule

// File: rtl/neurotransmitter_modulator.sv
// Mood-loop feedback path: decodes emotion/stimulus/sleep into per-channel
// requests, runs the shared decay timer and packs five levels onto a 10-bit bus.
module neurotransmitter_modulator
    import mood_pkg::*;
#(
    parameter int unsigned WIDTH       = 6,
    parameter int unsigned BASELINE    = 32,
    parameter int unsigned DECAY_TICKS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic [7:0]          action,
    input  logic [15:0]         stimuli,
    input  logic [7:0]          emotional_state,
    output logic [NT_BUS_W-1:0] neurotransmitter_level,
    output logic                level_changed
);

    localparam int unsigned CNT_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DECAY_TICKS - 1);
    localparam logic [WIDTH-1:0] L_BASE = WIDTH'(BASELINE);
    localparam logic [NT_BUS_W-1:0] BUS_RST = {NT_NUM{L_BASE[WIDTH-1 -: NT_SLOT_W]}};

    nt_req_t           w_req;
    logic              w_asleep;
    logic              w_decay;
    logic [WIDTH-1:0]  w_level [NT_NUM];
    logic [NT_BUS_W-1:0] w_nt_bus;
    logic [CNT_W-1:0]  r_decay_cnt;
    logic [NT_BUS_W-1:0] r_prev_bus;
    logic              r_level_changed;

    wire w_unused = ^{action[7:1], stimuli[15:14], stimuli[STIM_TIRED], stimuli[10:0]};

    assign w_asleep = action[ACT_ASLEEP];

    always_comb begin
        w_req = '0;
        w_req.inc[CH_CORT] = emotional_state[EMO_STRESSED] | stimuli[STIM_STARVING];
        w_req.dec[CH_CORT] = emotional_state[EMO_HAPPY] | emotional_state[EMO_CALM] | w_asleep;
        w_req.inc[CH_DOP]  = emotional_state[EMO_HAPPY] | emotional_state[EMO_EXCITED];
        w_req.dec[CH_DOP]  = emotional_state[EMO_BORED] | emotional_state[EMO_APATHETIC];
        w_req.inc[CH_GABA] = emotional_state[EMO_CALM] | w_asleep;
        w_req.dec[CH_GABA] = emotional_state[EMO_NERVOUS] | emotional_state[EMO_STRESSED];
        w_req.inc[CH_NE]   = emotional_state[EMO_EXCITED] | emotional_state[EMO_STRESSED]
                           | emotional_state[EMO_NERVOUS] | emotional_state[EMO_ANGRY];
        w_req.dec[CH_NE]   = emotional_state[EMO_CALM] | w_asleep | emotional_state[EMO_BORED];
        w_req.inc[CH_SER]  = emotional_state[EMO_HAPPY] | emotional_state[EMO_CALM];
        w_req.dec[CH_SER]  = emotional_state[EMO_ANGRY] | emotional_state[EMO_APATHETIC]
                           | stimuli[STIM_HUNGRY];
    end

    // Decay phase counts ticks only; the last phase of each period fires the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_decay_cnt <= '0;
        end else if (tick) begin
            r_decay_cnt <= (r_decay_cnt == CNT_MAX) ? '0 : r_decay_cnt + CNT_W'(1);
        end
    end

    assign w_decay = tick && (r_decay_cnt == CNT_MAX);

    for (genvar g = 0; g < NT_NUM; g++) begin : g_ch
        nt_channel #(
            .WIDTH    (WIDTH),
            .BASELINE (BASELINE)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .inc   (w_req.inc[g]),
            .dec   (w_req.dec[g]),
            .decay (w_decay),
            .level (w_level[g])
        );
    end

    assign w_nt_bus[NT_CORT +: NT_SLOT_W] = w_level[CH_CORT][WIDTH-1 -: NT_SLOT_W];
    assign w_nt_bus[NT_DOP  +: NT_SLOT_W] = w_level[CH_DOP][WIDTH-1 -: NT_SLOT_W];
    assign w_nt_bus[NT_GABA +: NT_SLOT_W] = w_level[CH_GABA][WIDTH-1 -: NT_SLOT_W];
    assign w_nt_bus[NT_NE   +: NT_SLOT_W] = w_level[CH_NE][WIDTH-1 -: NT_SLOT_W];
    assign w_nt_bus[NT_SER  +: NT_SLOT_W] = w_level[CH_SER][WIDTH-1 -: NT_SLOT_W];

    // Change detector compares the bus with its value one cycle earlier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_bus      <= BUS_RST;
            r_level_changed <= 1'b0;
        end else begin
            r_prev_bus      <= w_nt_bus;
            r_level_changed <= (w_nt_bus != r_prev_bus);
        end
    end

    assign neurotransmitter_level = w_nt_bus;
    assign level_changed          = r_level_changed;

endmodule

// File: tb/tb_neurotransmitter_modulator.sv
// Bench for neurotransmitter_modulator: hand-computed vector table, corner
// sequences (reset hold, saturation, decay timing, async reset) and a random run.
module tb_neurotransmitter_modulator;

    logic        clk;
    logic        rst;
    logic        tick;
    logic [7:0]  action;
    logic [15:0] stimuli;
    logic [7:0]  emotional_state;
    logic [9:0]  neurotransmitter_level;
    logic        level_changed;

    int n_checks;
    int n_fail;

    neurotransmitter_modulator dut (
        .clk                    (clk),
        .rst                    (rst),
        .tick                   (tick),
        .action                 (action),
        .stimuli                (stimuli),
        .emotional_state        (emotional_state),
        .neurotransmitter_level (neurotransmitter_level),
        .level_changed          (level_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  emo;
        logic [15:0] stim;
        logic [7:0]  act;
        int          n;
        logic [9:0]  exp;
    } vec_t;

    vec_t vecs [12];

    // Reference model: channel order CORT, DOP, GABA, NE, SER; levels 0..63.
    int lv [5];
    int dcnt;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act_v, exp_v);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) lv[i] = 32;
        dcnt = 0;
    endfunction

    function automatic void model_tick(input logic [7:0] e, input logic [15:0] s, input logic [7:0] a);
        bit inc [5];
        bit dec [5];
        bit decay;
        inc[0] = e[2] || s[12];
        dec[0] = e[0] || e[6] || a[0];
        inc[1] = e[0] || e[1];
        dec[1] = e[4] || e[7];
        inc[2] = e[6] || a[0];
        dec[2] = e[3] || e[2];
        inc[3] = e[1] || e[2] || e[3] || e[5];
        dec[3] = e[6] || a[0] || e[4];
        inc[4] = e[0] || e[6];
        dec[4] = e[5] || e[7] || s[11];
        decay = (dcnt == 7);
        dcnt = (dcnt + 1) % 8;
        for (int i = 0; i < 5; i++) begin
            if (inc[i] && !dec[i])      lv[i] = (lv[i] < 63) ? lv[i] + 1 : 63;
            else if (dec[i] && !inc[i]) lv[i] = (lv[i] > 0) ? lv[i] - 1 : 0;
            else if (!inc[i] && !dec[i] && decay) begin
                if (lv[i] > 32)      lv[i] = lv[i] - 1;
                else if (lv[i] < 32) lv[i] = lv[i] + 1;
            end
        end
    endfunction

    function automatic logic [9:0] model_bus();
        logic [9:0] b;
        b = '0;
        for (int i = 0; i < 5; i++) b = b | (10'(lv[i] / 16) << (2 * i));
        return b;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_ticks(input int n);
        tick = 1'b1;
        repeat (n) @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic set_in(input logic [7:0] e, input logic [15:0] s, input logic [7:0] a);
        emotional_state = e;
        stimuli = s;
        action = a;
    endtask

    initial begin
        int pulses;
        logic [9:0] hist1, hist2, exp_bus;
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        tick = 1'b0;
        set_in(8'h00, 16'h0000, 8'h00);

        vecs[0]  = '{8'h04, 16'h0000, 8'h00, 15, 10'h29A};
        vecs[1]  = '{8'h04, 16'h0000, 8'h00, 16, 10'h2DB};
        vecs[2]  = '{8'h04, 16'h0000, 8'h00, 17, 10'h2CB};
        vecs[3]  = '{8'h04, 16'h0000, 8'h00, 32, 10'h2CB};
        vecs[4]  = '{8'h01, 16'h0000, 8'h00, 16, 10'h3AD};
        vecs[5]  = '{8'h05, 16'h0000, 8'h00, 50, 10'h3CE};
        vecs[6]  = '{8'h80, 16'h0800, 8'h00, 32, 10'h0A2};
        vecs[7]  = '{8'h80, 16'h0800, 8'h00, 40, 10'h0A2};
        vecs[8]  = '{8'h00, 16'h0000, 8'h01, 1,  10'h269};
        vecs[9]  = '{8'h00, 16'h2000, 8'h00, 20, 10'h2AA};
        vecs[10] = '{8'h00, 16'h1000, 8'h00, 16, 10'h2AB};
        vecs[11] = '{8'h20, 16'h0000, 8'h00, 16, 10'h1EA};

        // Reset state held with tick low and arbitrary inputs.
        do_reset();
        for (int c = 0; c < 100; c++) begin
            set_in(8'($urandom), 16'($urandom), 8'($urandom));
            @(negedge clk);
            check("idle_bus", 32'(neurotransmitter_level), 32'h2AA);
            check("idle_chg", 32'(level_changed), 32'h0);
        end

        // Vector table, each entry from a fresh reset.
        for (int v = 0; v < 12; v++) begin
            do_reset();
            set_in(vecs[v].emo, vecs[v].stim, vecs[v].act);
            run_ticks(vecs[v].n);
            check($sformatf("vec%0d", v), 32'(neurotransmitter_level), 32'(vecs[v].exp));
        end

        // level_changed pulses once per bus transition under sustained stress.
        do_reset();
        set_in(8'h04, 16'h0000, 8'h00);
        pulses = 0;
        tick = 1'b1;
        for (int c = 0; c < 43; c++) begin
            if (c == 40) tick = 1'b0;
            @(negedge clk);
            if (level_changed) pulses++;
        end
        check("stress_pulses", 32'(pulses), 32'd3);
        check("stress_final", 32'(neurotransmitter_level), 32'h2CB);

        // Decay back to baseline from saturation.
        do_reset();
        set_in(8'h04, 16'h0000, 8'h00);
        run_ticks(32);
        check("decay_start", 32'(neurotransmitter_level), 32'h2CB);
        set_in(8'h00, 16'h0000, 8'h00);
        run_ticks(127);
        check("decay_127", 32'(neurotransmitter_level), 32'h2CB);
        run_ticks(1);
        check("decay_128", 32'(neurotransmitter_level), 32'h29A);
        run_ticks(120);
        check("decay_248", 32'(neurotransmitter_level), 32'h29A);
        run_ticks(8);
        check("decay_256", 32'(neurotransmitter_level), 32'h2AA);
        set_in(8'h01, 16'h0000, 8'h00);
        run_ticks(1);
        check("decay_exact_base", 32'(neurotransmitter_level), 32'h2A9);

        // Asynchronous reset between edges, then decay phase restarts.
        do_reset();
        set_in(8'h04, 16'h0000, 8'h00);
        run_ticks(20);
        check("prerst_bus", 32'(neurotransmitter_level), 32'h2CB);
        tick = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_bus", 32'(neurotransmitter_level), 32'h2AA);
        check("async_rst_chg", 32'(level_changed), 32'h0);
        tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        set_in(8'h00, 16'h0000, 8'h01);
        @(negedge clk);
        run_ticks(1);
        set_in(8'h00, 16'h0000, 8'h00);
        run_ticks(6);
        check("postrst_7", 32'(neurotransmitter_level), 32'h269);
        run_ticks(1);
        check("postrst_8", 32'(neurotransmitter_level), 32'h2AA);

        // Random run against the reference model, including level_changed.
        do_reset();
        model_reset();
        hist1 = 10'h2AA;
        hist2 = 10'h2AA;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(1, 0) == 1)
                emotional_state = 8'(1 << $urandom_range(7, 0));
            else
                emotional_state = 8'($urandom);
            if ($urandom_range(3, 0) == 0) emotional_state = 8'h00;
            stimuli = 16'($urandom);
            action = 8'($urandom);
            tick = ($urandom_range(9, 0) < 7);
            @(negedge clk);
            if (tick) model_tick(emotional_state, stimuli, action);
            exp_bus = model_bus();
            check("rand_bus", 32'(neurotransmitter_level), 32'(exp_bus));
            check("rand_chg", 32'(level_changed), 32'(hist1 != hist2));
            hist2 = hist1;
            hist1 = exp_bus;
        end
        tick = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
